// File: rtl/alu_operand_loader.sv
// alu_operand_loader: assembles byte-stream x/y operand pairs for the ALU.
// Optional internal exhaustive x/y sweep when ALU_OPERAND_SWEEP_EN is defined.
module alu_operand_loader #(
    parameter  int DATA_W = 16,
    localparam int NBYTES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              abort,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic              op_valid,
    input  logic              op_ready,
`ifdef ALU_OPERAND_SWEEP_EN
    input  logic              sweep_start,
    output logic              sweep_done,
`endif
    output logic [15:0]       pair_cnt
);

    // Narrow sweep builds (DATA_W < 8) still get one byte of shadow.
    localparam int NB = (NBYTES < 1) ? 1 : NBYTES;
    localparam int SW = NB * 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        LOAD_X,
        LOAD_Y,
        PRESENT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [SW-1:0] shadow_x;
    logic [SW-1:0] shadow_y;
    logic [SW-1:0] y_full;
    logic          xfer;
    logic          last;
    logic          hs;
    logic          sweeping;
    logic          start;
    logic          sweep_end;

`ifndef ALU_OPERAND_SWEEP_EN
    assign sweeping = 1'b0;
    assign start    = 1'b0;
`endif

    // Handshake qualifiers and next-state selection.
    always_comb begin
        state_nxt = state;
        in_ready  = (state != PRESENT) && !sweeping;
        xfer      = in_valid && in_ready && !abort && !start;
        last      = (idx == IW'(NB - 1));
        hs        = op_valid && op_ready && !abort;
        sweep_end = hs && sweeping && (&x_out) && (&y_out);
        y_full    = shadow_y;
        y_full[idx*8 +: 8] = in_byte;
        if (abort) begin
            state_nxt = LOAD_X;
        end else begin
            case (state)
                LOAD_X: begin
                    if (start)
                        state_nxt = PRESENT;
                    else if (xfer && last)
                        state_nxt = LOAD_Y;
                end
                LOAD_Y: begin
                    if (xfer && last)
                        state_nxt = PRESENT;
                end
                PRESENT: begin
                    if (hs && (!sweeping || sweep_end))
                        state_nxt = LOAD_X;
                end
                default: state_nxt = LOAD_X;
            endcase
        end
    end

`ifdef ALU_OPERAND_SWEEP_EN
    // Sweep may only begin at a clean pair boundary.
    assign start = sweep_start && (state == LOAD_X) &&
                   (idx == '0) && !abort;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOAD_X;
        else
            state <= state_nxt;
    end

    // Byte assembly, pair presentation, pair counting and sweep stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            shadow_x <= '0;
            shadow_y <= '0;
            x_out    <= '0;
            y_out    <= '0;
            op_valid <= 1'b0;
            pair_cnt <= '0;
`ifdef ALU_OPERAND_SWEEP_EN
            sweeping   <= 1'b0;
            sweep_done <= 1'b0;
`endif
        end else begin
`ifdef ALU_OPERAND_SWEEP_EN
            sweep_done <= 1'b0;
`endif
            if (abort) begin
                idx      <= '0;
                op_valid <= 1'b0;
`ifdef ALU_OPERAND_SWEEP_EN
                sweeping <= 1'b0;
`endif
            end else begin
                if (xfer) begin
                    if (state == LOAD_X)
                        shadow_x[idx*8 +: 8] <= in_byte;
                    else
                        shadow_y <= y_full;
                    idx <= last ? '0 : idx + 1'b1;
                    if (last && state == LOAD_Y) begin
                        x_out    <= shadow_x[DATA_W-1:0];
                        y_out    <= y_full[DATA_W-1:0];
                        op_valid <= 1'b1;
                    end
                end
                if (hs) begin
                    pair_cnt <= pair_cnt + 16'd1;
                    if (!sweeping) begin
                        op_valid <= 1'b0;
                    end else if (sweep_end) begin
                        op_valid <= 1'b0;
`ifdef ALU_OPERAND_SWEEP_EN
                        sweeping   <= 1'b0;
                        sweep_done <= 1'b1;
`endif
                    end else begin
                        {x_out, y_out} <= {x_out, y_out} + 1'b1;
                    end
                end
`ifdef ALU_OPERAND_SWEEP_EN
                if (start) begin
                    sweeping <= 1'b1;
                    x_out    <= '0;
                    y_out    <= '0;
                    op_valid <= 1'b1;
                end
`endif
            end
        end
    end

endmodule
